// File: rtl/uart_pkg.sv
// UART MMIO shared definitions: register offsets, STATUS bit positions
// and the TX/RX frame state encodings.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_FERR     = 4;
    localparam int ST_OVR      = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO for the UART byte queues.
// A push into a full FIFO succeeds only when a pop frees a slot that cycle.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         w_data,
    output logic [WIDTH-1:0]         r_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign r_data  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= w_data;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with 16x oversampled receiver and TX/RX FIFOs.
// Optional UART_MMIO_LOOPBACK_EN adds a CTRL register with internal loopback.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int DIV        = 27,
    parameter int FIFO_DEPTH = 16,
    parameter int DBITS      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [31:0] w_data,
    input  logic        we,
    input  logic        re,
    output logic [31:0] r_data,
    output logic        rx_empty,
    output logic        full,
    input  logic        rx,
    output logic        tx
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0] reg_sel;
    assign reg_sel = address[1:0];

    // ---------------- baud tick ----------------
    logic [DW-1:0] baud_cnt;
    logic          tick;
    assign tick = (baud_cnt == DW'(DIV - 1));

    // Free-running divider producing one tick per 1/16 bit.
    always_ff @(posedge clk) begin
        if (reset)     baud_cnt <= '0;
        else if (tick) baud_cnt <= '0;
        else           baud_cnt <= baud_cnt + 1'b1;
    end

    // ---------------- FIFOs ----------------
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [DBITS-1:0] tx_head;
    logic [CW-1:0]    tx_count;
    logic             rx_push, rx_pop, rx_full;
    logic [DBITS-1:0] rx_head, rx_shift;
    logic [CW-1:0]    rx_count;

    assign tx_push = we && (reg_sel == REG_DATA);
    assign rx_pop  = re && (reg_sel == REG_DATA);

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DBITS)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (tx_push),
        .pop    (tx_pop),
        .w_data (w_data[DBITS-1:0]),
        .r_data (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DBITS)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (rx_push),
        .pop    (rx_pop),
        .w_data (rx_shift),
        .r_data (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

    assign full = tx_full;

    // ---------------- TX FSM ----------------
    tx_state_t        tx_state, tx_state_n;
    logic [3:0]       tx_tcnt, tx_tcnt_n;
    logic [BW-1:0]    tx_bcnt, tx_bcnt_n;
    logic [DBITS-1:0] tx_sh, tx_sh_n;
    logic             tx_ser;

    // Transmitter state and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_sh    <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_tcnt  <= tx_tcnt_n;
            tx_bcnt  <= tx_bcnt_n;
            tx_sh    <= tx_sh_n;
        end
    end

    // Frame sequencing; the next byte is fetched straight from STOP.
    always_comb begin
        tx_state_n = tx_state;
        tx_tcnt_n  = tx_tcnt;
        tx_bcnt_n  = tx_bcnt;
        tx_sh_n    = tx_sh;
        tx_pop     = 1'b0;
        if (tick) begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_sh_n    = tx_head;
                        tx_tcnt_n  = '0;
                        tx_state_n = TX_START;
                    end
                end
                TX_START: begin
                    tx_tcnt_n = tx_tcnt + 1'b1;
                    if (tx_tcnt == 4'd15) begin
                        tx_bcnt_n  = '0;
                        tx_state_n = TX_DATA;
                    end
                end
                TX_DATA: begin
                    tx_tcnt_n = tx_tcnt + 1'b1;
                    if (tx_tcnt == 4'd15) begin
                        tx_sh_n = tx_sh >> 1;
                        if (tx_bcnt == BW'(DBITS - 1)) tx_state_n = TX_STOP;
                        else tx_bcnt_n = tx_bcnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    tx_tcnt_n = tx_tcnt + 1'b1;
                    if (tx_tcnt == 4'd15) begin
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_sh_n    = tx_head;
                            tx_state_n = TX_START;
                        end else begin
                            tx_state_n = TX_IDLE;
                        end
                    end
                end
                default: tx_state_n = TX_IDLE;
            endcase
        end
    end

    assign tx_ser = (tx_state == TX_START) ? 1'b0 :
                    (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;

    // ---------------- RX path ----------------
    logic rx_s1, rx_s2, rx_in;

    // Two-flop synchroniser for the asynchronous rx pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

`ifdef UART_MMIO_LOOPBACK_EN
    logic loopback;

    // CTRL register: bit0 routes tx back into the receiver.
    always_ff @(posedge clk) begin
        if (reset) loopback <= 1'b0;
        else if (we && (reg_sel == REG_CTRL)) loopback <= w_data[0];
    end

    assign rx_in = loopback ? tx_ser : rx_s2;
    assign tx    = loopback ? 1'b1 : tx_ser;
`else
    assign rx_in = rx_s2;
    assign tx    = tx_ser;
`endif

    rx_state_t        rx_state, rx_state_n;
    logic [3:0]       rx_tcnt, rx_tcnt_n;
    logic [BW-1:0]    rx_bcnt, rx_bcnt_n;
    logic [DBITS-1:0] rx_shift_n;
    logic             ferr_set;

    // Receiver state and deserialiser.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_bcnt  <= rx_bcnt_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Mid-bit sampling: start checked 8 ticks in, then every 16 ticks.
    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_bcnt_n  = rx_bcnt;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        if (tick) begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (!rx_in) begin
                        rx_tcnt_n  = '0;
                        rx_state_n = RX_START;
                    end
                end
                RX_START: begin
                    rx_tcnt_n = rx_tcnt + 1'b1;
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt_n  = '0;
                        rx_bcnt_n  = '0;
                        rx_state_n = rx_in ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_tcnt_n = rx_tcnt + 1'b1;
                    if (rx_tcnt == 4'd15) begin
                        rx_shift_n = {rx_in, rx_shift[DBITS-1:1]};
                        if (rx_bcnt == BW'(DBITS - 1)) rx_state_n = RX_STOP;
                        else rx_bcnt_n = rx_bcnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    rx_tcnt_n = rx_tcnt + 1'b1;
                    if (rx_tcnt == 4'd15) begin
                        rx_push    = rx_in;
                        ferr_set   = !rx_in;
                        rx_state_n = RX_IDLE;
                    end
                end
                default: rx_state_n = RX_IDLE;
            endcase
        end
    end

    // ---------------- status and register decode ----------------
    logic ovr, ferr, ovr_set, st_clr;
    logic [5:0] status;

    assign ovr_set = rx_push && rx_full && !rx_pop;
    assign st_clr  = re && (reg_sel == REG_STATUS);

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovr_set)     ovr <= 1'b1;
            else if (st_clr) ovr <= 1'b0;
            if (ferr_set)    ferr <= 1'b1;
            else if (st_clr) ferr <= 1'b0;
        end
    end

    assign status[ST_TX_EMPTY] = tx_empty;
    assign status[ST_TX_FULL]  = tx_full;
    assign status[ST_RX_EMPTY] = rx_empty;
    assign status[ST_RX_FULL]  = rx_full;
    assign status[ST_FERR]     = ferr;
    assign status[ST_OVR]      = ovr;

    // Read mux; an empty RX FIFO reads as zero.
    always_comb begin
        r_data = '0;
        case (reg_sel)
            REG_DATA:   if (!rx_empty) r_data = {{(32 - DBITS){1'b0}}, rx_head};
            REG_STATUS: r_data = {26'b0, status};
`ifdef UART_MMIO_LOOPBACK_EN
            REG_CTRL:   r_data = {31'b0, loopback};
`else
            REG_CTRL:   r_data = '0;
`endif
            default:    r_data = '0;
        endcase
    end

    // Address and data bits with no register behind them.
    logic unused_ok;
    assign unused_ok = ^{tx_count, rx_count, address[15:2], w_data[31:DBITS]};

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio (DIV=4, 64 clocks per bit).
// TX frames decoded by a monitor against a scoreboard; RX via register reads.
module tb_uart_mmio;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [31:0] w_data;
    logic        we, re;
    logic [31:0] r_data;
    logic        rx_empty, full, rx, tx;

    uart_mmio #(.DIV(DIV), .FIFO_DEPTH(16), .DBITS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .w_data   (w_data),
        .we       (we),
        .re       (re),
        .r_data   (r_data),
        .rx_empty (rx_empty),
        .full     (full),
        .rx       (rx),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_tx[$];
    logic [7:0] sb_rx[$];
    int tx_gen  = 0;
    int tx_done = 0;
    int tx_low  = 0;
    bit exp_ovr  = 0;
    bit exp_ferr = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {26'b0, exp_ovr, exp_ferr, sb_rx.size() == 16,
                sb_rx.size() == 0, 1'b0, 1'b1};
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        address = {14'b0, a};
        w_data  = v;
        we      = 1'b1;
        @(negedge clk);
        we      = 1'b0;
        address = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic pop,
                      output logic [31:0] d);
        @(negedge clk);
        address = {14'b0, a};
        re      = pop;
        #1 d = r_data;
        @(negedge clk);
        re      = 1'b0;
        address = '0;
    endtask

    task automatic rd_rx(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        e = (sb_rx.size() != 0) ? sb_rx.pop_front() : 8'h00;
        rd(2'd0, 1'b1, d);
        check(tag, d, {24'b0, e});
    endtask

    task automatic send(input logic [7:0] b, input logic stop,
                        input bit probe);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        if (probe) check("rx_empty_pre_stop", rx_empty, 1);
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        if (stop) begin
            if (sb_rx.size() < 16) sb_rx.push_back(b);
            else exp_ovr = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
        if (probe) check("rx_empty_post_stop", rx_empty, 0);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_done < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("tx_wait", tx_done >= n, 1);
    endtask

    // TX monitor: decode each frame at mid-bit and score it.
    initial begin
        forever begin
            logic [7:0] b;
            logic       s0, s1;
            int         g;
            @(negedge tx);
            g = tx_gen;
            tx_low++;
            repeat (BIT / 2) @(negedge clk);
            s0 = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            s1 = tx;
            if (g == tx_gen) begin
                check("tx_start_bit", s0, 0);
                check("tx_stop_bit", s1, 1);
                check("tx_pending", sb_tx.size() != 0, 1);
                if (sb_tx.size() != 0) check("tx_byte", b, sb_tx.pop_front());
                tx_done++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int k, n, tl;
        reset = 1'b1; address = '0; w_data = '0;
        we = 1'b0; re = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_tx", tx, 1);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_full", full, 0);
        check("rst_rdata", r_data, 0);
        rd(2'd1, 1'b0, d);
        check("rst_status", d, 32'h05);

        sb_tx.push_back(8'h55);
        wr(2'd0, 32'h55);
        k = 0;
        while (tx !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        n = 0;
        while (tx === 1'b0 && n < 200) begin @(negedge clk); n++; end
        check("tx_start_len", n, BIT);
        wait_tx(1);
        rd(2'd1, 1'b0, d);
        check("tx_status_after", d, exp_status());

        send(8'hA3, 1'b1, 1'b1);
        rd_rx("rx_a3");
        check("rx_empty_after_pop", rx_empty, 1);

        for (int i = 0; i < 17; i++) send(8'h40 + 8'(i * 7), 1'b1, 1'b0);
        rd(2'd1, 1'b1, d);
        check("ovr_status", d, exp_status());
        exp_ovr = 1'b0;
        for (int i = 0; i < 16; i++) rd_rx("ovr_fifo_byte");
        rd(2'd1, 1'b0, d);
        check("ovr_cleared", d, exp_status());
        rd_rx("rx_pop_empty");

        send(8'h5A, 1'b0, 1'b0);
        repeat (BIT) @(negedge clk);
        rd(2'd1, 1'b1, d);
        check("ferr_status", d, exp_status());
        exp_ferr = 1'b0;
        rd(2'd1, 1'b0, d);
        check("ferr_cleared", d, exp_status());
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_no_frame", rx_empty, 1);
        send(8'hC6, 1'b1, 1'b0);
        rd_rx("rx_after_glitch");

        rd(2'd2, 1'b0, d);
        check("addr2_reads_0", d, 0);

`ifdef UART_MMIO_LOOPBACK_EN
        tl = tx_low;
        wr(2'd3, 32'h1);
        rd(2'd3, 1'b0, d);
        check("ctrl_readback", d, 1);
        wr(2'd0, 32'h3C);
        sb_rx.push_back(8'h3C);
        k = 0;
        while (rx_empty && k < 2000) begin @(negedge clk); k++; end
        rd_rx("loopback_byte");
        check("loopback_tx_idle", tx_low, tl);
        wr(2'd3, 32'h0);
`else
        wr(2'd3, 32'h1);
        rd(2'd3, 1'b0, d);
        check("addr3_reads_0", d, 0);
`endif

        n = tx_done;
        for (int i = 0; i < 17; i++) begin
            sb_tx.push_back(8'h10 + 8'(i));
            wr(2'd0, 32'h10 + i);
            if (i == 15) check("full_after_16", full, 0);
        end
        check("full_after_17", full, 1);
        wait_tx(n + 2);
        repeat (3 * BIT) @(negedge clk);
        check("tx_mid_frame_busy", full, 0);
        reset = 1'b1;
        tx_gen++;
        sb_tx.delete();
        @(posedge clk);
        #1 check("rst_mid_tx", tx, 1);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_full", full, 0);
        check("rst_mid_rx_empty", rx_empty, 1);
        rd(2'd1, 1'b0, d);
        check("rst_mid_status", d, 32'h05);
        tl = tx_low;
        repeat (2 * BIT) @(negedge clk);
        check("rst_mid_tx_quiet", tx_low, tl);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
